// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the fetch buffer: the fetch/decode packet,
// the NOP encoding used for empty output slots, and default sizing.
package fetch_buffer_pkg;

   // Default superscalar width and queue depth (depth must be a power of two, >= 2*width).
   localparam int FB_N     = 3;
   localparam int FB_DEPTH = 8;

   // RISC-V canonical NOP (addi x0, x0, 0).
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
      logic [31:0] PC;
      logic [31:0] NPC;
   } IF_ID_PACKET;

   // Packet driven on any output slot that does not hold a live entry.
   function automatic IF_ID_PACKET empty_packet();
      IF_ID_PACKET p;
      p.valid = 1'b0;
      p.inst  = NOP;
      p.PC    = 32'h0;
      p.NPC   = 32'h0;
      return p;
   endfunction

endpackage

// File: rtl/fb_compactor.sv
// Maps the per-slot valid bits of an incoming bundle to dense write offsets
// (exclusive prefix popcount) and the total number of valid slots.
module fb_compactor
   import fetch_buffer_pkg::*;
#(
   parameter int N  = FB_N,
   parameter int DW = $clog2(N + 1)
) (
   input  logic [N-1:0]  valid,
   output logic [DW-1:0] offset [N],
   output logic [DW-1:0] enq_n
);

   // Running count of valid slots seen so far gives each slot its offset from tail.
   always_comb begin
      logic [DW-1:0] acc;
      acc = '0;
      for (int i = 0; i < N; i++) begin
         offset[i] = acc;
         acc       = acc + DW'(valid[i]);
      end
      enq_n = acc;
   end

endmodule

// File: rtl/fetch_buffer.sv
// N-wide circular instruction queue between branch prediction and dispatch.
// Compacts valid slots of each predicted bundle into program order and
// presents the oldest N entries to dispatch.
//
// Flow control: the incoming bundle is taken on a clock edge only when
// fb_stall is low and squash_flag is low at that edge; fb_stall acts as the
// inverse of "ready" and depends only on registered occupancy, so fetch can
// treat (any slot valid && !fb_stall) as a completed transfer. On the output
// side each fb_packet_out slot's .valid is the offer and dispatch_num is the
// number of leading slots consumed; requests beyond occupancy are clamped.
module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter int N     = FB_N,
   parameter int DEPTH = FB_DEPTH
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       squash_flag,
   input  IF_ID_PACKET                bp_packet_in [N],
   input  logic [$clog2(N+1)-1:0]     dispatch_num,
   output IF_ID_PACKET                fb_packet_out [N],
   output logic [$clog2(DEPTH+1)-1:0] fb_count,
   output logic                       fb_stall
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int DW = $clog2(N + 1);

   IF_ID_PACKET   mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic [N-1:0]  in_valid;
   logic [DW-1:0] offset [N];
   logic [DW-1:0] enq_raw;
   logic [DW-1:0] enq_n;
   logic [DW-1:0] deq_n;
   logic [CW-1:0] free_slots;
   logic          do_enq;

   // Gather the per-slot valid bits for the compactor.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         in_valid[i] = bp_packet_in[i].valid;
      end
   end

   fb_compactor #(.N(N), .DW(DW)) u_compactor (
      .valid  (in_valid),
      .offset (offset),
      .enq_n  (enq_raw)
   );

   // Stall is a pure function of registered occupancy so it never loops back through dispatch.
   assign free_slots = CW'(DEPTH) - count;
   assign fb_stall   = free_slots < CW'(N);
   assign do_enq     = !fb_stall && !squash_flag;
   assign enq_n      = do_enq ? enq_raw : '0;
   assign deq_n      = (CW'(dispatch_num) > count) ? DW'(count) : dispatch_num;
   assign fb_count   = count;

   // Pointer and occupancy update; squash and reset both empty the queue.
   always_ff @(posedge clock) begin
      if (reset || squash_flag) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(deq_n);
         tail  <= tail + PW'(enq_n);
         count <= count + CW'(enq_n) - CW'(deq_n);
      end
   end

   // Write each valid slot at tail plus its compacted offset; indices wrap naturally.
   always_ff @(posedge clock) begin
      if (!reset && do_enq) begin
         for (int i = 0; i < N; i++) begin
            if (in_valid[i]) begin
               mem[tail + PW'(offset[i])] <= bp_packet_in[i];
            end
         end
      end
   end

   // Present the oldest N entries; slots past occupancy or during squash show an empty NOP.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         fb_packet_out[i] = empty_packet();
         if ((CW'(i) < count) && !squash_flag) begin
            fb_packet_out[i]       = mem[head + PW'(i)];
            fb_packet_out[i].valid = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with N=3, DEPTH=8: reset state, enqueue
// compaction, stall/release, full, wrap-around ordering, squash and reset
// during enqueue.
module tb_fetch_buffer;
   import fetch_buffer_pkg::*;

   localparam int N     = 3;
   localparam int DEPTH = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic        squash_flag;
   IF_ID_PACKET bp_packet_in  [N];
   logic [1:0]  dispatch_num;
   IF_ID_PACKET fb_packet_out [N];
   logic [3:0]  fb_count;
   logic        fb_stall;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q [$];

   fetch_buffer #(.N(N), .DEPTH(DEPTH)) dut (
      .clock         (clock),
      .reset         (reset),
      .squash_flag   (squash_flag),
      .bp_packet_in  (bp_packet_in),
      .dispatch_num  (dispatch_num),
      .fb_packet_out (fb_packet_out),
      .fb_count      (fb_count),
      .fb_stall      (fb_stall)
   );

   // Clock and reset
   always #5 clock = ~clock;

   // Scoreboard compare
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Driver: bundle at base, base+4, base+8 with per-slot valid mask, plus dispatch request.
   task automatic present(input logic [2:0] v, input logic [31:0] base, input logic [1:0] dnum);
      for (int i = 0; i < N; i++) begin
         bp_packet_in[i].valid = v[i];
         bp_packet_in[i].PC    = base + 32'(4 * i);
         bp_packet_in[i].NPC   = base + 32'(4 * i + 4);
         bp_packet_in[i].inst  = 32'hA500_0000 | (base + 32'(4 * i));
      end
      dispatch_num = dnum;
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push3(input logic [2:0] v, input logic [31:0] base);
      for (int i = 0; i < N; i++) begin
         if (v[i]) exp_q.push_back(base + 32'(4 * i));
      end
   endtask

   task automatic pop_n(input int n);
      for (int i = 0; i < n; i++) begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
   endtask

   // Compare the oldest n output slots against the head of the expected queue.
   task automatic check_front(input int n);
      for (int i = 0; i < n; i++) begin
         check($sformatf("out%0d_valid", i), 64'(fb_packet_out[i].valid), 64'd1);
         if (i < exp_q.size())
            check($sformatf("out%0d_pc", i), 64'(fb_packet_out[i].PC), 64'(exp_q[i]));
         else
            check($sformatf("out%0d_pc_noexp", i), 64'(fb_packet_out[i].PC), 64'hFFFF_FFFF_FFFF);
         check($sformatf("out%0d_inst", i), 64'(fb_packet_out[i].inst),
               64'(32'hA500_0000 | fb_packet_out[i].PC));
      end
   endtask

   task automatic check_empty_slot(input int i);
      check($sformatf("out%0d_valid0", i), 64'(fb_packet_out[i].valid), 64'd0);
      check($sformatf("out%0d_nop", i), 64'(fb_packet_out[i].inst), 64'(NOP));
      check($sformatf("out%0d_pc0", i), 64'(fb_packet_out[i].PC), 64'd0);
   endtask

   initial begin
      reset       = 1'b1;
      squash_flag = 1'b0;
      present(3'b000, 32'h0, 2'd0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;

      // Reset state
      check("reset_count", 64'(fb_count), 64'd0);
      check("reset_stall", 64'(fb_stall), 64'd0);
      for (int i = 0; i < N; i++) check_empty_slot(i);

      // Full bundle into empty queue
      present(3'b111, 32'h0, 2'd0);
      push3(3'b111, 32'h0);
      tick();
      present(3'b000, 32'h0, 2'd0);
      check("enq3_count", 64'(fb_count), 64'd3);
      check_front(3);
      present(3'b000, 32'h0, 2'd3);
      tick();
      pop_n(3);
      present(3'b000, 32'h0, 2'd0);
      check("drain3_count", 64'(fb_count), 64'd0);

      // Compaction of pattern {1,0,1}
      present(3'b101, 32'h10, 2'd0);
      push3(3'b101, 32'h10);
      tick();
      present(3'b000, 32'h0, 2'd0);
      check("compact_count", 64'(fb_count), 64'd2);
      check_front(2);
      check_empty_slot(2);

      // Over-request is clamped to occupancy, then empty clamps to zero
      present(3'b000, 32'h0, 2'd3);
      tick();
      pop_n(2);
      check("clamp_count", 64'(fb_count), 64'd0);
      tick();
      check("empty_clamp_count", 64'(fb_count), 64'd0);
      check_empty_slot(0);

      // Fill to 6 (head=tail=5 before this)
      present(3'b111, 32'h20, 2'd0);
      push3(3'b111, 32'h20);
      tick();
      present(3'b111, 32'h2C, 2'd0);
      push3(3'b111, 32'h2C);
      tick();
      present(3'b000, 32'h0, 2'd0);
      check("fill6_count", 64'(fb_count), 64'd6);
      check("fill6_stall", 64'(fb_stall), 64'd1);

      // Stall cycle: bundle dropped while two entries dispatch
      present(3'b111, 32'h40, 2'd2);
      check("stall_cycle", 64'(fb_stall), 64'd1);
      tick();
      pop_n(2);
      present(3'b000, 32'h0, 2'd0);
      check("after_stall_count", 64'(fb_count), 64'd4);
      check("release_stall", 64'(fb_stall), 64'd0);
      check_front(3);

      // Re-presented bundle accepted alongside one dequeue: 7 - 1
      present(3'b111, 32'h40, 2'd1);
      push3(3'b111, 32'h40);
      tick();
      pop_n(1);
      present(3'b000, 32'h0, 2'd0);
      check("reaccept_count", 64'(fb_count), 64'd6);
      check_front(3);
      present(3'b000, 32'h0, 2'd3);
      tick();
      pop_n(3);
      present(3'b000, 32'h0, 2'd0);
      check("drain_to3_count", 64'(fb_count), 64'd3);
      check_front(3);

      // Fill to DEPTH across the wrap point (writes at 6,7 then 0,1,2)
      present(3'b011, 32'h50, 2'd0);
      push3(3'b011, 32'h50);
      tick();
      present(3'b111, 32'h60, 2'd0);
      push3(3'b111, 32'h60);
      tick();
      present(3'b000, 32'h0, 2'd0);
      check("full_count", 64'(fb_count), 64'd8);
      check("full_stall", 64'(fb_stall), 64'd1);
      present(3'b111, 32'h70, 2'd0);
      tick();
      present(3'b000, 32'h0, 2'd0);
      check("full_drop_count", 64'(fb_count), 64'd8);
      check_front(3);

      // Wrap ordering: entry6, entry7, entry0
      present(3'b000, 32'h0, 2'd3);
      tick();
      pop_n(3);
      present(3'b000, 32'h0, 2'd0);
      check("wrap_count", 64'(fb_count), 64'd5);
      check("wrap_stall", 64'(fb_stall), 64'd0);
      check_front(3);
      present(3'b000, 32'h0, 2'd3);
      tick();
      pop_n(3);
      present(3'b000, 32'h0, 2'd0);
      check("wrap_drain_count", 64'(fb_count), 64'd2);
      check_front(2);

      // Squash with count 5, full bundle and dispatch request
      present(3'b111, 32'h80, 2'd0);
      push3(3'b111, 32'h80);
      tick();
      present(3'b000, 32'h0, 2'd0);
      check("presquash_count", 64'(fb_count), 64'd5);
      squash_flag = 1'b1;
      present(3'b111, 32'h90, 2'd3);
      for (int i = 0; i < N; i++) check_empty_slot(i);
      tick();
      squash_flag = 1'b0;
      exp_q.delete();
      present(3'b000, 32'h0, 2'd0);
      check("squash_count", 64'(fb_count), 64'd0);
      check("squash_stall", 64'(fb_stall), 64'd0);
      check_empty_slot(0);

      // Post-squash enqueue starts from a clean head
      present(3'b111, 32'hA0, 2'd0);
      push3(3'b111, 32'hA0);
      tick();
      present(3'b000, 32'h0, 2'd0);
      check("postsquash_count", 64'(fb_count), 64'd3);
      check_front(3);

      // Reset during an enqueue discards the bundle
      present(3'b111, 32'hB0, 2'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      present(3'b000, 32'h0, 2'd0);
      check("reset_enq_count", 64'(fb_count), 64'd0);
      check_empty_slot(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

N-wide circular instruction queue between the branch predictor and decode/dispatch. It accepts the predicted `IF_ID_PACKET` bundle each cycle and compacts out invalid slots. It holds packets in program order and presents the oldest N to dispatch. It back-pressures fetch when it cannot absorb a full bundle, and it empties on a squash.

## Interface
- `N`, default `` `N `` (sys_defs): superscalar width.
- `DEPTH`, default `` `FB_DEPTH `` (8): entries; power of two, ≥ 2·N.

- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `squash_flag`  in  1  flush all entries (mispredict/exception).
- `bp_packet_in`  in  IF_ID_PACKET[N]  predicted bundle; per-slot `.valid`.
- `dispatch_num`  in  $clog2(N+1)  entries dispatch consumes this cycle (0..N).
- `fb_packet_out`  out  IF_ID_PACKET[N]  oldest N entries, slot 0 oldest.
- `fb_count`  out  $clog2(DEPTH+1)  current occupancy.
- `fb_stall`  out  1  fetch must hold its PC; the bundle presented this cycle is not accepted.

## Operation
- State: `head`, `tail` ($clog2(DEPTH) bits), `count`, `DEPTH` entry array.
- `fb_stall = (DEPTH - count) < N`. Computed from registered `count` only, not from this cycle's dequeue.
- Enqueue, when `!fb_stall && !squash_flag`:
  - Valid slots of `bp_packet_in` are written in slot order to `tail`, `tail+1`, … (mod DEPTH). Invalid slots are skipped.
  - `enq_n` = popcount of the valid bits.
  - When `fb_stall=1`, the bundle is dropped entirely. Fetch re-presents it.
- Dequeue:
  - `deq_n = min(dispatch_num, count)`.
  - `head` advances by `deq_n` mod DEPTH.
- Update: `count_next = count + enq_n - deq_n`. Enqueue and dequeue in the same cycle are legal. Dequeued entries never overlap the entries being written.
- Output slot i:
  - Valid iff `i < count` and `!squash_flag`; then it carries entry `(head+i) mod DEPTH`.
  - Otherwise `.valid=0`, `.inst=NOP`, `.PC=0`, `.NPC=0`.
- Squash:
  - Overrides enqueue and dequeue. Next state is `head=tail=count=0`.
  - All outputs are invalid during the squash cycle.
- Reset: `head=tail=count=0`; all `fb_packet_out` invalid/NOP/zero; `fb_count=0`; `fb_stall=0`.

## Timing
- Enqueue-to-output latency is 1 cycle. An entry written at edge k is visible on `fb_packet_out` in cycle k+1 at the earliest.
- `fb_packet_out`, `fb_count` and `fb_stall` depend only on registers, except for the combinational `squash_flag` masking of valids.
- Boundary behaviour:
  - Empty: all outputs invalid; `dispatch_num > 0` is clamped to 0.
  - Full (`count=DEPTH`): `fb_stall=1`.
  - Wrap-around: both pointers wrap mod DEPTH; program order is preserved across index DEPTH-1 → 0.
  - Stall release: in the cycle after a dequeue raises free space to ≥ N, `fb_stall` drops.
- Reset or squash in the middle of an enqueue discards the incoming bundle.

## Structure
- `FB_DEPTH` goes in `sys_defs.svh`. `IF_ID_PACKET` and `NOP` already live there.
- One natural combinational sub-module: `fb_compactor`. It maps the N valid bits to per-slot write offsets (prefix popcount) plus `enq_n`.
- Storage, pointers and output muxing stay in `fetch_buffer`.

## Test plan
All scenarios use N=3, DEPTH=8.
- Reset → `fb_count=0`, `fb_stall=0`, all three outputs `.valid=0` and `.inst=NOP`.
- Enqueue PCs 0x0/0x4/0x8 (all valid), `dispatch_num=0` → next cycle `fb_count=3`, outputs PCs 0x0/0x4/0x8, all valid.
- Valid pattern {1,0,1} with PCs 0x10/0x14/0x18 into an empty buffer → next cycle `fb_count=2`, out[0].PC=0x10, out[1].PC=0x18, out[2] invalid.
- Stall and release:
  - Cycle 1: `count=6`, full bundle in, `dispatch_num=2` → `fb_stall=1`, bundle dropped, next `fb_count=4`.
  - Cycle 2: `fb_stall=0`; the re-presented bundle is accepted → `fb_count = 7 - deq_n`.
- Wrap: `head=6`, `count=2`, enqueue 3 → entries land at indices 0,1,2. With `dispatch_num=3`, outputs are in order entry6, entry7, entry0.
- Squash with `count=5`, a full bundle in and `dispatch_num=3` → squash-cycle outputs all invalid; next cycle `fb_count=0` and `fb_stall=0`.
